uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//   UART receiver: the receive end of the UART link whose transmitter serializes
//   a start/data/parity/stop frame bit by bit through a select-driven MUX.
//   Oversamples rx_in, detects the start bit and majority-votes each bit at mid-period.
//   Shifts in data LSB-first, then checks the parity and stop bits.
//   Presents p_data with a one-cycle data_valid, or a one-cycle error flag.
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame
//   OVERSAMPLE  8  CLK cycles per bit; even and >= 4
// PORTS
//   CLK         in   1           system clock, rising edge
//   RST         in   1           asynchronous active-low reset
//   rx_in       in   1           serial line, idle high, asynchronous to CLK
//   par_en      in   1           1 = frame carries a parity bit
//   par_typ     in   1           0 = even, 1 = odd parity
//   p_data      out  DATA_WIDTH  last good received word
//   data_valid  out  1           one-cycle pulse: p_data updated
//   par_err     out  1           one-cycle pulse: parity mismatch
//   stp_err     out  1           one-cycle pulse: stop bit sampled 0
// BEHAVIOUR
// - Reset values: p_data=0, data_valid=0, par_err=0, stp_err=0, FSM=IDLE, counters=0.
//   The synchronizer FFs reset to 1.
// - rx_in passes through a 2-FF synchronizer; all logic uses the synced signal rxs.
// - tick counter runs 0..OVERSAMPLE-1 and wraps; bit_cnt runs 0..DATA_WIDTH-1.
// - Sampling: rxs is captured at ticks M-1, M and M+1, where M = OVERSAMPLE/2.
//   The bit decision is the 2-of-3 majority, registered at tick M+1.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE->START: rxs is 0 while previous rxs was 1. tick is cleared to 0.
//     par_en and par_typ are latched at this point and held for the frame.
//   START: a decision of 1 is a glitch -> back to IDLE with no output.
//     A decision of 0 -> DATA at the next tick wrap.
//   DATA: each decision shifts into bit bit_cnt (LSB first).
//     After bit DATA_WIDTH-1 completes, go to PARITY if latched par_en, else STOP.
//   PARITY: compute the XOR of the data bits and the parity bit.
//     It must be 0 for even parity and 1 for odd; otherwise set the internal perr.
//   STOP: decision taken at tick M+1. The next cycle applies these outputs:
//     no error (stop=1, !perr): p_data <= shift register, data_valid=1.
//     error: par_err=perr and stp_err=!stop; p_data keeps its old value.
//     Both errors may pulse together. FSM goes to IDLE in that same cycle.
// - Returning to IDLE at mid-stop lets a back-to-back frame be detected on schedule.
//   A falling edge is needed to start a frame; a line stuck low after a stop error
//   does not retrigger.
// - Latency: data_valid rises M+2 cycles after the stop bit's first synced cycle.
//   It is a one-cycle pulse with no handshake; the consumer must capture it.
// - Reset asserted mid-frame returns to IDLE immediately; the partial frame is discarded.
// TESTING (OVERSAMPLE=8, DATA_WIDTH=8)
// 1. par_en=1, par_typ=0; send 0xA5, parity 0, stop 1
//    -> single data_valid pulse, p_data=0xA5, par_err=stp_err=0.
// 2. Same frame with parity bit 1
//    -> par_err pulses once, data_valid stays 0, p_data remains 0xA5.
// 3. Send 0x3C with stop=0, then line high and a good 0x3C frame
//    -> stp_err pulses once, then data_valid with p_data=0x3C.
// 4. rx_in low for 2 cycles, then high -> no pulses, FSM in IDLE.
//    1-cycle low pulse at tick M of a data bit -> majority keeps the bit value.
// 5. par_en=0; back-to-back 0x00 then 0xFF with no idle gap
//    -> two data_valid pulses 10 bit-times apart, p_data 0x00 then 0xFF.
// 6. Assert RST during DATA bit 4, release, send 0x5A
//    -> outputs read 0 during reset, and no pulse for the aborted frame.
//    The 0x5A frame then gives data_valid with p_data=0x5A.

Source files
------------

// File: rtl/uart_rx_frame_if.sv
// Signal bundle between a UART serial line plus its frame settings and the
// parallel receive side. The master drives the line; the slave is the receiver.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output rx_in, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err
  );

  modport slave (
    input  rx_in, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART frame receiver: start/data/optional parity/stop, 2-of-3 vote
// around mid-bit, one-cycle pulses for a good word, parity error or stop error.
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input logic            CLK,
  input logic            RST,
  uart_rx_frame_if.slave bus
);

  localparam int M      = OVERSAMPLE / 2;
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TICK_W-1:0] T_PRE  = TICK_W'(M - 1);
  localparam logic [TICK_W-1:0] T_MID  = TICK_W'(M);
  localparam logic [TICK_W-1:0] T_POST = TICK_W'(M + 1);
  localparam logic [TICK_W-1:0] T_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  B_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, rxs_q, rxs_prev_q;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  s_pre_q, s_pre_d, s_mid_q, s_mid_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  perr_q, perr_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  maj, decide, tick_wrap;

  // Third sample is the live synced value, so the vote is ready at tick M+1.
  assign maj       = (s_pre_q & s_mid_q) | (s_pre_q & rxs_q) | (s_mid_q & rxs_q);
  assign decide    = (tick_q == T_POST);
  assign tick_wrap = (tick_q == T_LAST);

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_wrap ? '0 : tick_q + TICK_W'(1);
    bit_cnt_d    = bit_cnt_q;
    s_pre_d      = (tick_q == T_PRE) ? rxs_q : s_pre_q;
    s_mid_d      = (tick_q == T_MID) ? rxs_q : s_mid_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    perr_d       = perr_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tick_d    = '0;
        bit_cnt_d = '0;
        // The edge-detect cycle is tick 0 of the start bit, so counting resumes at 1.
        if (!rxs_q && rxs_prev_q) begin
          state_d   = START;
          tick_d    = TICK_W'(1);
          par_en_d  = bus.par_en;
          par_typ_d = bus.par_typ;
          perr_d    = 1'b0;
        end
      end
      START: begin
        if (decide && maj) begin
          state_d = IDLE;
          tick_d  = '0;
        end else if (tick_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d[bit_cnt_q] = maj;
        end
        if (tick_wrap) begin
          if (bit_cnt_q == B_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (decide) begin
          perr_d = (^shift_q) ^ maj ^ par_typ_q;
        end
        if (tick_wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop keeps us aligned for a back-to-back start bit.
        if (decide) begin
          state_d = IDLE;
          tick_d  = '0;
          if (maj && !perr_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end else begin
            par_err_d = perr_q;
            stp_err_d = !maj;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      s_pre_q      <= 1'b1;
      s_mid_q      <= 1'b1;
      shift_q      <= '0;
      p_data_q     <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      perr_q       <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      sync1_q      <= bus.rx_in;
      rxs_q        <= sync1_q;
      rxs_prev_q   <= rxs_q;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      s_pre_q      <= s_pre_d;
      s_mid_q      <= s_mid_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      perr_q       <= perr_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames plus random frames
// compared against a frame-level model (parity by bit count, expected pulse timing).
module tb_uart_rx_frame;

  localparam int DW = 8;
  localparam int OS = 8;
  localparam int M  = OS / 2;
  localparam int LAT = 2 + M + 2;  // synchronizer + vote/output latency from stop drive

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] exp_pdata;

  int            dv_cyc[$];
  logic [DW-1:0] dv_val[$];
  int            pe_cyc[$];
  int            se_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_frame #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.data_valid) begin
        dv_cyc.push_back(cyc);
        dv_val.push_back(bus.p_data);
      end
      if (bus.par_err) pe_cyc.push_back(cyc);
      if (bus.stp_err) se_cyc.push_back(cyc);
    end
  end

  function automatic logic parity_ok(logic [DW-1:0] d, logic pbit, logic typ);
    return ((($countones(d) + int'(pbit)) % 2) == int'(typ));
  endfunction

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    dv_cyc.delete();
    dv_val.delete();
    pe_cyc.delete();
    se_cyc.delete();
  endtask

  task automatic drive_bit(input logic b, input int glitch_at);
    for (int j = 0; j < OS; j++) begin
      bus.rx_in = (j == glitch_at) ? ~b : b;
      tick_n(1);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit,
                            input logic stop, input int glitch_bit, input logic scramble,
                            output int stop_cyc);
    drive_bit(1'b0, -1);
    if (scramble) begin
      bus.par_en  = 1'($urandom);
      bus.par_typ = 1'($urandom);
    end
    for (int i = 0; i < DW; i++) drive_bit(d[i], (i == glitch_bit) ? M : -1);
    if (pen) drive_bit(pbit, -1);
    stop_cyc = cyc;
    drive_bit(stop, -1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.par_typ = 1'b0;
    tick_n(3);
    checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", bus.data_valid); end
    checks++; if (bus.par_err !== 1'b0) begin failures++; $display("FAIL reset_pe got=%b exp=0", bus.par_err); end
    checks++; if (bus.stp_err !== 1'b0) begin failures++; $display("FAIL reset_se got=%b exp=0", bus.stp_err); end
    checks++; if (bus.p_data !== '0) begin failures++; $display("FAIL reset_pdata got=%h exp=00", bus.p_data); end
    rst_n = 1'b1;
    exp_pdata = '0;
    tick_n(4);
  endtask

  task automatic test_parity_good();
    int sc;
    clear_mon();
    bus.par_en = 1'b1; bus.par_typ = 1'b0;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, 1'b0, sc);
    bus.rx_in = 1'b1;
    tick_n(2 * OS);
    exp_pdata = 8'hA5;
    $display("frame parity_good data=a5 dv=%0d pe=%0d se=%0d", dv_cyc.size(), pe_cyc.size(), se_cyc.size());
    checks++; if (dv_cyc.size() != 1) begin failures++; $display("FAIL pgood_dv_count got=%0d exp=1", dv_cyc.size()); end
    if (dv_cyc.size() == 1) begin
      checks++; if (dv_val[0] !== 8'hA5) begin failures++; $display("FAIL pgood_data got=%h exp=a5", dv_val[0]); end
      checks++; if (dv_cyc[0] != sc + LAT) begin failures++; $display("FAIL pgood_latency got=%0d exp=%0d", dv_cyc[0] - sc, LAT); end
    end
    checks++; if (pe_cyc.size() + se_cyc.size() != 0) begin failures++; $display("FAIL pgood_errs got=%0d exp=0", pe_cyc.size() + se_cyc.size()); end
    checks++; if (bus.p_data !== exp_pdata) begin failures++; $display("FAIL pgood_pdata got=%h exp=%h", bus.p_data, exp_pdata); end
  endtask

  task automatic test_parity_error();
    int sc;
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, 1'b0, sc);
    bus.rx_in = 1'b1;
    tick_n(2 * OS);
    $display("frame parity_bad data=a5 dv=%0d pe=%0d se=%0d", dv_cyc.size(), pe_cyc.size(), se_cyc.size());
    checks++; if (pe_cyc.size() != 1) begin failures++; $display("FAIL perr_count got=%0d exp=1", pe_cyc.size()); end
    if (pe_cyc.size() == 1) begin
      checks++; if (pe_cyc[0] != sc + LAT) begin failures++; $display("FAIL perr_latency got=%0d exp=%0d", pe_cyc[0] - sc, LAT); end
    end
    checks++; if (dv_cyc.size() + se_cyc.size() != 0) begin failures++; $display("FAIL perr_other got=%0d exp=0", dv_cyc.size() + se_cyc.size()); end
    checks++; if (bus.p_data !== exp_pdata) begin failures++; $display("FAIL perr_pdata got=%h exp=%h", bus.p_data, exp_pdata); end
  endtask

  task automatic test_stop_error();
    int sc;
    clear_mon();
    bus.par_en = 1'b1; bus.par_typ = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1, 1'b0, sc);
    tick_n(2 * OS);  // line stays low: must not retrigger
    bus.rx_in = 1'b1;
    tick_n(2 * OS);
    $display("frame stop_bad data=3c dv=%0d pe=%0d se=%0d", dv_cyc.size(), pe_cyc.size(), se_cyc.size());
    checks++; if (se_cyc.size() != 1) begin failures++; $display("FAIL serr_count got=%0d exp=1", se_cyc.size()); end
    checks++; if (dv_cyc.size() + pe_cyc.size() != 0) begin failures++; $display("FAIL serr_other got=%0d exp=0", dv_cyc.size() + pe_cyc.size()); end
    checks++; if (bus.p_data !== exp_pdata) begin failures++; $display("FAIL serr_pdata got=%h exp=%h", bus.p_data, exp_pdata); end
    clear_mon();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, 1'b0, sc);
    bus.rx_in = 1'b1;
    tick_n(2 * OS);
    exp_pdata = 8'h3C;
    $display("frame stop_recover data=3c dv=%0d pe=%0d se=%0d", dv_cyc.size(), pe_cyc.size(), se_cyc.size());
    checks++; if (dv_cyc.size() != 1) begin failures++; $display("FAIL srec_dv_count got=%0d exp=1", dv_cyc.size()); end
    checks++; if (bus.p_data !== exp_pdata) begin failures++; $display("FAIL srec_pdata got=%h exp=%h", bus.p_data, exp_pdata); end
  endtask

  task automatic test_glitch();
    int sc;
    clear_mon();
    bus.rx_in = 1'b0;
    tick_n(2);
    bus.rx_in = 1'b1;
    tick_n(3 * OS);
    $display("glitch start dv=%0d pe=%0d se=%0d", dv_cyc.size(), pe_cyc.size(), se_cyc.size());
    checks++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() != 0) begin failures++; $display("FAIL glitch_start_pulses got=%0d exp=0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
    bus.par_en = 1'b0;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 2, 1'b0, sc);
    bus.rx_in = 1'b1;
    tick_n(2 * OS);
    exp_pdata = 8'hFF;
    $display("frame glitch_data data=ff dv=%0d", dv_cyc.size());
    checks++; if (dv_cyc.size() != 1) begin failures++; $display("FAIL glitch_dv_count got=%0d exp=1", dv_cyc.size()); end
    if (dv_cyc.size() == 1) begin
      checks++; if (dv_val[0] !== 8'hFF) begin failures++; $display("FAIL glitch_data got=%h exp=ff", dv_val[0]); end
      checks++; if (dv_cyc[0] != sc + LAT) begin failures++; $display("FAIL glitch_latency got=%0d exp=%0d", dv_cyc[0] - sc, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    int sc0, sc1;
    clear_mon();
    bus.par_en = 1'b0;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1, 1'b0, sc0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, 1'b0, sc1);
    bus.rx_in = 1'b1;
    tick_n(2 * OS);
    exp_pdata = 8'hFF;
    $display("frames back_to_back 00,ff dv=%0d", dv_cyc.size());
    checks++; if (dv_cyc.size() != 2) begin failures++; $display("FAIL b2b_dv_count got=%0d exp=2", dv_cyc.size()); end
    if (dv_cyc.size() == 2) begin
      checks++; if (dv_val[0] !== 8'h00) begin failures++; $display("FAIL b2b_first got=%h exp=00", dv_val[0]); end
      checks++; if (dv_val[1] !== 8'hFF) begin failures++; $display("FAIL b2b_second got=%h exp=ff", dv_val[1]); end
      checks++; if (dv_cyc[1] - dv_cyc[0] != 10 * OS) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", dv_cyc[1] - dv_cyc[0], 10 * OS); end
    end
  endtask

  task automatic test_random();
    int sc;
    logic [DW-1:0] d;
    logic pen, typ, pbit, stop, exp_dv, exp_pe, exp_se;
    for (int f = 0; f < 16; f++) begin
      clear_mon();
      d    = DW'($urandom);
      pen  = 1'($urandom);
      typ  = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      bus.par_en  = pen;
      bus.par_typ = typ;
      send_frame(d, pen, pbit, stop, -1, 1'b1, sc);
      bus.rx_in = 1'b1;
      tick_n(OS + $urandom_range(0, OS - 1));
      exp_pe = pen && !parity_ok(d, pbit, typ);
      exp_se = !stop;
      exp_dv = !exp_pe && !exp_se;
      if (exp_dv) exp_pdata = d;
      $display("frame rand %0d data=%h pen=%0d typ=%0d pbit=%0d stop=%0d dv=%0d pe=%0d se=%0d",
               f, d, pen, typ, pbit, stop, dv_cyc.size(), pe_cyc.size(), se_cyc.size());
      checks++; if (dv_cyc.size() != int'(exp_dv)) begin failures++; $display("FAIL rand_dv got=%0d exp=%0d", dv_cyc.size(), exp_dv); end
      checks++; if (pe_cyc.size() != int'(exp_pe)) begin failures++; $display("FAIL rand_pe got=%0d exp=%0d", pe_cyc.size(), exp_pe); end
      checks++; if (se_cyc.size() != int'(exp_se)) begin failures++; $display("FAIL rand_se got=%0d exp=%0d", se_cyc.size(), exp_se); end
      checks++; if (bus.p_data !== exp_pdata) begin failures++; $display("FAIL rand_pdata got=%h exp=%h", bus.p_data, exp_pdata); end
      if (exp_pe && exp_se && pe_cyc.size() == 1 && se_cyc.size() == 1) begin
        checks++; if (pe_cyc[0] != se_cyc[0]) begin failures++; $display("FAIL rand_both_same_cycle got=%0d exp=%0d", se_cyc[0], pe_cyc[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int sc;
    logic [DW-1:0] d;
    clear_mon();
    bus.par_en = 1'b0;
    d = 8'hC3;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(d[i], -1);
    bus.rx_in = d[4];
    tick_n(M);
    rst_n = 1'b0;
    tick_n(2);
    checks++; if (bus.p_data !== '0) begin failures++; $display("FAIL rstmid_pdata got=%h exp=00", bus.p_data); end
    checks++; if ({bus.data_valid, bus.par_err, bus.stp_err} !== 3'b000) begin failures++; $display("FAIL rstmid_flags got=%b exp=000", {bus.data_valid, bus.par_err, bus.stp_err}); end
    bus.rx_in = 1'b1;
    tick_n(2);
    rst_n = 1'b1;
    exp_pdata = '0;
    tick_n(3 * OS);
    checks++; if (dv_cyc.size() + pe_cyc.size() + se_cyc.size() != 0) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=0", dv_cyc.size() + pe_cyc.size() + se_cyc.size()); end
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, 1'b0, sc);
    bus.rx_in = 1'b1;
    tick_n(2 * OS);
    exp_pdata = 8'h5A;
    $display("frame after_reset data=5a dv=%0d", dv_cyc.size());
    checks++; if (dv_cyc.size() != 1) begin failures++; $display("FAIL rstmid_dv_count got=%0d exp=1", dv_cyc.size()); end
    checks++; if (bus.p_data !== exp_pdata) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", bus.p_data, exp_pdata); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_in = 1'b1;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    exp_pdata = '0;
    #1;
    test_reset();
    test_parity_good();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
